// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared payload types, sizing constants and wakeup helpers
// for the collapsing issue queue.
`ifndef NUM_INSTRS_COMPLETED
`define NUM_INSTRS_COMPLETED 2
`endif

package issue_queue_pkg;

    localparam int IQ_DEPTH_DEFAULT = 16;
    localparam int PREG_W           = 6;
    localparam int NUM_PREGS        = 1 << PREG_W;
    localparam int TAG_W            = 8;

    // One renamed instruction as delivered by the rename stage.
    typedef struct packed {
        logic              valid;
        logic              uses_rs1;
        logic [PREG_W-1:0] rs1;
        logic              rs1_ready;
        logic              uses_rs2;
        logic [PREG_W-1:0] rs2;
        logic              rs2_ready;
        logic              uses_rd;
        logic [PREG_W-1:0] rd;
        logic [TAG_W-1:0]  tag;
    } rename_out_t;

    // One writeback broadcast.
    typedef struct packed {
        logic              valid;
        logic              uses_rd;
        logic [PREG_W-1:0] rd;
    } wb_t;

    // Stored queue entry: rename payload plus live source-ready bits.
    typedef struct packed {
        logic              uses_rs1;
        logic [PREG_W-1:0] rs1;
        logic              rs1_ready;
        logic              uses_rs2;
        logic [PREG_W-1:0] rs2;
        logic              rs2_ready;
        logic              uses_rd;
        logic [PREG_W-1:0] rd;
        logic [TAG_W-1:0]  tag;
    } iq_entry_t;

    // OR any broadcast physical register into the entry's source-ready bits.
    function automatic iq_entry_t wake_entry(input iq_entry_t e, input logic [NUM_PREGS-1:0] wake);
        iq_entry_t r;
        r           = e;
        r.rs1_ready = e.rs1_ready | wake[e.rs1];
        r.rs2_ready = e.rs2_ready | wake[e.rs2];
        return r;
    endfunction

    // Convert an incoming renamed instruction into a stored entry, applying
    // same-cycle wakeup so a producer broadcasting now is not missed.
    function automatic iq_entry_t to_entry(input rename_out_t ro, input logic [NUM_PREGS-1:0] wake);
        iq_entry_t r;
        r           = '0;
        r.uses_rs1  = ro.uses_rs1;
        r.rs1       = ro.rs1;
        r.rs1_ready = ro.rs1_ready;
        r.uses_rs2  = ro.uses_rs2;
        r.rs2       = ro.rs2;
        r.rs2_ready = ro.rs2_ready;
        r.uses_rd   = ro.uses_rd;
        r.rd        = ro.rd;
        r.tag       = ro.tag;
        return wake_entry(r, wake);
    endfunction

endpackage

// File: rtl/issue_queue_select.sv
// iq_select: priority encoder returning the lowest set index of a request
// vector; index 0 is the oldest queue entry, so this picks oldest-ready.
module iq_select #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest requesting index wins.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// issue_queue: collapsing in-order-age issue queue with writeback wakeup and
// zero-latency oldest-ready select. Optional build macro IQ_PERF_COUNTERS_EN
// adds perf_issued / perf_full_cycles counters.
`ifndef NUM_INSTRS_COMPLETED
`define NUM_INSTRS_COMPLETED 2
`endif

module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT,
    parameter int NUM_WB   = `NUM_INSTRS_COMPLETED
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ext_flush,
    input  rename_out_t               i_renamed [2],
    input  wb_t                       i_wb [NUM_WB],
    output logic                      o_issue_valid,
    input  logic                      i_issue_ready,
    output iq_entry_t                 o_issue_entry,
    output logic                      int_stall,
    output logic [$clog2(IQ_DEPTH):0] occupancy
`ifdef IQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]               perf_issued,
    output logic [31:0]               perf_full_cycles
`endif
);

    localparam int IDX_W = $clog2(IQ_DEPTH);
    localparam int OCC_W = IDX_W + 1;

    iq_entry_t             entry_reg  [IQ_DEPTH];
    iq_entry_t             entry_next [IQ_DEPTH];
    iq_entry_t             comp_entry [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]   valid_reg;
    logic [IQ_DEPTH-1:0]   valid_next;
    logic [IQ_DEPTH-1:0]   comp_valid;
    logic [IQ_DEPTH-1:0]   ready_vec;
    logic [IQ_DEPTH-1:0]   shift_mask;
    logic [OCC_W-1:0]      occupancy_reg;
    logic [OCC_W-1:0]      occupancy_next;
    logic [OCC_W-1:0]      base;
    logic [OCC_W-1:0]      pos1;
    logic [NUM_PREGS-1:0]  wake_mask;
    logic                  sel_found;
    logic [IDX_W-1:0]      sel_idx;
    logic                  issue_fire;
    logic                  ins0;
    logic                  ins1;

    genvar gi;

    assign int_stall     = occupancy_reg > OCC_W'(IQ_DEPTH - 2);
    assign occupancy     = occupancy_reg;
    assign issue_fire    = sel_found & i_issue_ready;
    assign o_issue_valid = sel_found;
    assign o_issue_entry = sel_found ? entry_reg[sel_idx] : '0;
    assign ins0          = i_renamed[0].valid & ~int_stall & ~ext_flush;
    assign ins1          = i_renamed[1].valid & ~int_stall & ~ext_flush;

    // Decode all writeback ports into a one-hot-per-preg wakeup mask.
    always_comb begin
        wake_mask = '0;
        for (int j = 0; j < NUM_WB; j++) begin
            if (i_wb[j].valid && i_wb[j].uses_rd) begin
                wake_mask[i_wb[j].rd] = 1'b1;
            end
        end
    end

    // Entries at or above the issued index move down one slot.
    always_comb begin
        shift_mask = issue_fire ? ({IQ_DEPTH{1'b1}} << sel_idx) : '0;
    end

    // Per-entry readiness and post-issue compaction with wakeup applied.
    for (gi = 0; gi < IQ_DEPTH; gi++) begin : g_entry
        assign ready_vec[gi] = valid_reg[gi]
                             & (entry_reg[gi].rs1_ready | ~entry_reg[gi].uses_rs1)
                             & (entry_reg[gi].rs2_ready | ~entry_reg[gi].uses_rs2);
        if (gi < IQ_DEPTH - 1) begin : g_shift
            assign comp_valid[gi] = shift_mask[gi] ? valid_reg[gi+1] : valid_reg[gi];
            assign comp_entry[gi] = wake_entry(shift_mask[gi] ? entry_reg[gi+1] : entry_reg[gi],
                                               wake_mask);
        end else begin : g_last
            assign comp_valid[gi] = shift_mask[gi] ? 1'b0 : valid_reg[gi];
            assign comp_entry[gi] = wake_entry(entry_reg[gi], wake_mask);
        end
    end

    iq_select #(
        .N     (IQ_DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .req   (ready_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Append inserts after compaction; flush overrides everything.
    always_comb begin
        valid_next = comp_valid;
        entry_next = comp_entry;
        base       = occupancy_reg - OCC_W'(issue_fire);
        pos1       = base + OCC_W'(ins0);
        if (ins0) begin
            valid_next[base[IDX_W-1:0]] = 1'b1;
            entry_next[base[IDX_W-1:0]] = to_entry(i_renamed[0], wake_mask);
        end
        if (ins1) begin
            valid_next[pos1[IDX_W-1:0]] = 1'b1;
            entry_next[pos1[IDX_W-1:0]] = to_entry(i_renamed[1], wake_mask);
        end
        occupancy_next = pos1 + OCC_W'(ins1);
        if (ext_flush) begin
            valid_next     = '0;
            occupancy_next = '0;
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg     <= '0;
            occupancy_reg <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            valid_reg     <= valid_next;
            occupancy_reg <= occupancy_next;
            entry_reg     <= entry_next;
        end
    end

`ifdef IQ_PERF_COUNTERS_EN
    logic [31:0] perf_issued_reg;
    logic [31:0] perf_full_cycles_reg;

    // Free-running wrap-around counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issued_reg      <= '0;
            perf_full_cycles_reg <= '0;
        end else begin
            perf_issued_reg      <= perf_issued_reg + 32'(issue_fire);
            perf_full_cycles_reg <= perf_full_cycles_reg + 32'(int_stall);
        end
    end

    assign perf_issued      = perf_issued_reg;
    assign perf_full_cycles = perf_full_cycles_reg;
`endif

endmodule

// File: tb/tb_issue_queue.sv
// tb_issue_queue: directed stimulus against a queue-based reference model of
// the issue queue, compared every cycle, plus hand-computed literal checks.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int DEPTH = 16;
    localparam int NWB   = 2;

    logic        clk;
    logic        reset;
    logic        ext_flush;
    logic        i_issue_ready;
    rename_out_t ren [2];
    wb_t         wb [NWB];
    logic        o_issue_valid;
    iq_entry_t   o_issue_entry;
    logic        int_stall;
    logic [4:0]  occupancy;
`ifdef IQ_PERF_COUNTERS_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_full_cycles;
`endif

    int checks = 0;
    int errors = 0;
    iq_entry_t mq[$];

    issue_queue #(
        .IQ_DEPTH (DEPTH),
        .NUM_WB   (NWB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ext_flush        (ext_flush),
        .i_renamed        (ren),
        .i_wb             (wb),
        .o_issue_valid    (o_issue_valid),
        .i_issue_ready    (i_issue_ready),
        .o_issue_entry    (o_issue_entry),
        .int_stall        (int_stall),
        .occupancy        (occupancy)
`ifdef IQ_PERF_COUNTERS_EN
        ,
        .perf_issued      (perf_issued),
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_ready(input iq_entry_t e);
        return (e.rs1_ready || !e.uses_rs1) && (e.rs2_ready || !e.uses_rs2);
    endfunction

    function automatic bit m_woken(input logic [5:0] p);
        for (int j = 0; j < NWB; j++) begin
            if (wb[j].valid && wb[j].uses_rd && wb[j].rd == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_oldest_ready();
        for (int i = 0; i < mq.size(); i++) begin
            if (m_ready(mq[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit        stall;
        int        s;
        iq_entry_t e;
        stall = (mq.size() > DEPTH - 2);
        if (ext_flush) begin
            mq.delete();
            return;
        end
        s = m_oldest_ready();
        if (s >= 0 && i_issue_ready) mq.delete(s);
        foreach (mq[i]) begin
            if (m_woken(mq[i].rs1)) mq[i].rs1_ready = 1'b1;
            if (m_woken(mq[i].rs2)) mq[i].rs2_ready = 1'b1;
        end
        if (!stall) begin
            for (int k = 0; k < 2; k++) begin
                if (ren[k].valid) begin
                    e           = '0;
                    e.uses_rs1  = ren[k].uses_rs1;
                    e.rs1       = ren[k].rs1;
                    e.rs1_ready = ren[k].rs1_ready || m_woken(ren[k].rs1);
                    e.uses_rs2  = ren[k].uses_rs2;
                    e.rs2       = ren[k].rs2;
                    e.rs2_ready = ren[k].rs2_ready || m_woken(ren[k].rs2);
                    e.uses_rd   = ren[k].uses_rd;
                    e.rd        = ren[k].rd;
                    e.tag       = ren[k].tag;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic compare_outputs();
        int        s;
        iq_entry_t exp_e;
        s     = m_oldest_ready();
        exp_e = '0;
        if (s >= 0) exp_e = mq[s];
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("int_stall", 64'(int_stall), 64'(mq.size() > DEPTH - 2));
        chk("o_issue_valid", 64'(o_issue_valid), 64'(s >= 0));
        chk("o_issue_entry", 64'(o_issue_entry), 64'(exp_e));
    endtask

    // One clock: model follows the edge, outputs compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        if (!reset) mq.delete();
        else model_step();
        @(negedge clk);
        compare_outputs();
        $display("cycle t=%0t occ=%0d valid=%0b tag=0x%0h stall=%0b", $time, occupancy,
                 o_issue_valid, o_issue_entry.tag, int_stall);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic rename_out_t mk(input bit u1, input logic [5:0] r1, input bit r1rdy,
                                       input bit u2, input logic [5:0] r2, input bit r2rdy,
                                       input logic [7:0] tag);
        rename_out_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.uses_rs1  = u1;
        r.rs1       = r1;
        r.rs1_ready = r1rdy;
        r.uses_rs2  = u2;
        r.rs2       = r2;
        r.rs2_ready = r2rdy;
        r.uses_rd   = 1'b1;
        r.rd        = tag[5:0];
        r.tag       = tag;
        return r;
    endfunction

    function automatic wb_t mkwb(input logic [5:0] rd);
        wb_t w;
        w.valid   = 1'b1;
        w.uses_rd = 1'b1;
        w.rd      = rd;
        return w;
    endfunction

    task automatic idle();
        ren[0]    = '0;
        ren[1]    = '0;
        wb[0]     = '0;
        wb[1]     = '0;
        ext_flush = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        i_issue_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_valid", 64'(o_issue_valid), 64'd0);
        chk("rst_stall", 64'(int_stall), 64'd0);
        chk("rst_entry", 64'(o_issue_entry), 64'd0);
        reset = 1'b1;
        cycle();

        // Wakeup of a waiting source by a later writeback.
        ren[0] = mk(1'b1, 6'd5, 1'b0, 1'b0, 6'd0, 1'b0, 8'h01);
        cycle();
        idle();
        chk("t1_wait_valid", 64'(o_issue_valid), 64'd0);
        chk("t1_occ", 64'(occupancy), 64'd1);
        wb[0] = mkwb(6'd5);
        cycle();
        idle();
        chk("t1_woken_valid", 64'(o_issue_valid), 64'd1);
        chk("t1_rs1", 64'(o_issue_entry.rs1), 64'd5);
        i_issue_ready = 1'b1;
        cycle();
        i_issue_ready = 1'b0;
        chk("t1_drained", 64'(occupancy), 64'd0);

        // Backpressure holds the oldest entry; then both issue in order.
        ren[0] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h21);
        ren[1] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h22);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_tag", 64'(o_issue_entry.tag), 64'h21);
            cycle();
        end
        chk("t2_hold_tag_end", 64'(o_issue_entry.tag), 64'h21);
        i_issue_ready = 1'b1;
        cycle();
        chk("t2_second_tag", 64'(o_issue_entry.tag), 64'h22);
        cycle();
        i_issue_ready = 1'b0;
        chk("t2_empty", 64'(occupancy), 64'd0);

        // Fill to 15: stall asserts and inserts are dropped.
        for (int i = 0; i < 7; i++) begin
            ren[0] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'(8'h40 + 2 * i));
            ren[1] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'(8'h41 + 2 * i));
            cycle();
        end
        idle();
        ren[0] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h4e);
        cycle();
        chk("t3_occ15", 64'(occupancy), 64'd15);
        chk("t3_stall", 64'(int_stall), 64'd1);
        ren[0] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h70);
        ren[1] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h71);
        cycle();
        chk("t3_dropped", 64'(occupancy), 64'd15);
        i_issue_ready = 1'b1;
        cycle();
        idle();
        chk("t3_occ14", 64'(occupancy), 64'd14);
        chk("t3_unstall", 64'(int_stall), 64'd0);
        repeat (4) cycle();
        chk("t3_occ10", 64'(occupancy), 64'd10);

        // Flush with concurrent insert and issue handshake.
        ext_flush = 1'b1;
        ren[0]    = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h55);
        cycle();
        idle();
        i_issue_ready = 1'b0;
        chk("t5_occ", 64'(occupancy), 64'd0);
        chk("t5_valid", 64'(o_issue_valid), 64'd0);

        // Same-cycle wakeup on insert; writeback without uses_rd is ignored.
        ren[0]        = mk(1'b0, 6'd0, 1'b0, 1'b1, 6'd7, 1'b0, 8'h61);
        ren[1]        = mk(1'b1, 6'd9, 1'b0, 1'b0, 6'd0, 1'b0, 8'h62);
        wb[0]         = mkwb(6'd7);
        wb[1]         = mkwb(6'd9);
        wb[1].uses_rd = 1'b0;
        cycle();
        idle();
        chk("t4_valid", 64'(o_issue_valid), 64'd1);
        chk("t4_rs2_ready", 64'(o_issue_entry.rs2_ready), 64'd1);
        chk("t4_tag", 64'(o_issue_entry.tag), 64'h61);
        i_issue_ready = 1'b1;
        cycle();
        i_issue_ready = 1'b0;
        chk("t4_occ", 64'(occupancy), 64'd1);
        chk("t4_blocked", 64'(o_issue_valid), 64'd0);

        // Mixed traffic: inserts, wakeups and issues overlapping.
        for (int i = 0; i < 24; i++) begin
            idle();
            if (i % 2 == 0) ren[0] = mk(1'b1, 6'(i % 5 + 8), 1'b0, 1'b0, 6'd0, 1'b0, 8'(8'h80 + i));
            if (i % 3 == 0) ren[1] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'(8'hc0 + i));
            wb[0]         = mkwb(6'((i + 2) % 5 + 8));
            i_issue_ready = (i % 4 != 0);
            cycle();
        end
        idle();
        i_issue_ready = 1'b0;

        // Reset asserted mid-stream clears outputs immediately.
        ren[0] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h91);
        ren[1] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h92);
        cycle();
        i_issue_ready = 1'b1;
        reset         = 1'b0;
        #1;
        chk("t6_valid", 64'(o_issue_valid), 64'd0);
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_stall", 64'(int_stall), 64'd0);
        chk("t6_entry", 64'(o_issue_entry), 64'd0);
`ifdef IQ_PERF_COUNTERS_EN
        chk("t6_perf_issued", 64'(perf_issued), 64'd0);
        chk("t6_perf_full", 64'(perf_full_cycles), 64'd0);
`endif
        mq.delete();
        cycle();
        reset         = 1'b1;
        i_issue_ready = 1'b0;
        idle();
        cycle();
        chk("t6_post_occ", 64'(occupancy), 64'd0);
        ren[0] = mk(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 8'ha1);
        cycle();
        idle();
        chk("t6_restart_occ", 64'(occupancy), 64'd1);
        chk("t6_restart_tag", 64'(o_issue_entry.tag), 64'ha1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 16, number of entries (even, >=4).
REQ-002 SHALL have parameter NUM_WB, default `NUM_INSTRS_COMPLETED, number of wakeup ports.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low; state clears while low.
REQ-005 SHALL have port ext_flush  input  1  synchronous squash of all entries.
REQ-006 SHALL have port i_renamed[2]  rename_out_ifc.in  -  renamed instructions; slot 0 older than slot 1.
REQ-007 SHALL have port i_wb[NUM_WB]  wb_ifc.in  -  writeback broadcast; uses valid, uses_rd, rd (6-bit physical).
REQ-008 SHALL have port o_issue_valid  output  1  an oldest-ready entry is presented.
REQ-009 SHALL have port i_issue_ready  input  1  execute accepts the presented entry.
REQ-010 SHALL have port o_issue_entry  output  iq_entry_t  payload of the presented entry.
REQ-011 SHALL have port int_stall  output  1  queue cannot accept two instructions this cycle.
REQ-012 SHALL have port occupancy  output  clog2(IQ_DEPTH)+1  valid entry count.

Function
REQ-013 SHALL hold entries as a collapsing queue: index 0 oldest, valid entries contiguous from index 0.
REQ-014 SHALL assert int_stall combinationally when occupancy > IQ_DEPTH-2, with no dependence on the issue handshake.
REQ-015 SHALL, when int_stall is low and ext_flush is low, insert every i_renamed[k] with valid=1 at the tail in slot order; invalid slots are skipped without gaps.
REQ-016 SHALL ignore i_renamed while int_stall is high; upstream holds its data.
REQ-017 SHALL mark an entry ready when (rs1_ready or ~uses_rs1) and (rs2_ready or ~uses_rs2).
REQ-018 SHALL set rs1_ready/rs2_ready of a stored entry at the edge after any i_wb[j] with valid&uses_rd and rd equal to that source tag.
REQ-019 SHALL apply same-cycle wakeup to inserting instructions: the stored ready bit is the incoming bit OR a matching i_wb broadcast.
REQ-020 SHALL drive o_issue_valid/o_issue_entry combinationally from the lowest-index ready entry; zero-latency select.
REQ-021 SHALL remove the presented entry at the edge where o_issue_valid&i_issue_ready, shifting younger entries down one index.
REQ-022 SHALL keep the presented entry, with unchanged payload, while i_issue_ready is low.
REQ-023 SHALL update occupancy as old - issued + inserted when issue and insert coincide; issue compaction precedes tail append.
REQ-024 SHALL, on ext_flush, clear all valid bits at the next edge, overriding insert, issue and wakeup that cycle; o_issue_valid stays combinational in the flush cycle.
REQ-025 SHALL hold o_issue_valid low and all entries unchanged in the empty case, with insert permitted.

Reset
REQ-026 SHALL, while reset is low, clear all valid bits, force occupancy=0, o_issue_valid=0 and int_stall=0, and zero o_issue_entry.
REQ-027 SHALL discard in-flight inserts and issues when reset asserts mid-operation; the first post-reset edge starts empty.

Configuration
REQ-028 SHALL, with IQ_PERF_COUNTERS_EN defined, add 32-bit outputs perf_issued (increments per handshake) and perf_full_cycles (increments per cycle int_stall is high), both wrapping, cleared by reset, not by flush.
REQ-029 SHALL, without IQ_PERF_COUNTERS_EN, omit both ports and counters entirely.

Structure
REQ-030 SHALL define iq_entry_t (rename payload plus rs1_ready/rs2_ready) and IQ_DEPTH default in the shared package.
REQ-031 SHALL implement oldest-ready selection as sub-module iq_select (priority encoder over ready vector).

Verification
REQ-032 SHALL test: insert slot0 with rs1=p5 not ready, rs2 unused; wb rd=p5 next cycle -> o_issue_valid rises one cycle after wb and o_issue_entry.rs1=5.
REQ-033 SHALL test: insert two ready instrs with i_issue_ready=0 for 3 cycles -> slot-0 instr presented steadily; ready=1 -> slot 0 issues, then slot 1.
REQ-034 SHALL test: fill IQ_DEPTH=16 to 15 -> int_stall=1 and new inserts dropped; one issue -> occupancy 14, int_stall=0.
REQ-035 SHALL test: insert with same-cycle wb matching rs2 -> entry ready on the first cycle after insert.
REQ-036 SHALL test: 10 entries, ext_flush with concurrent insert and issue handshake -> occupancy 0 next cycle, o_issue_valid=0.
REQ-037 SHALL test: reset low mid-stream -> outputs zero immediately; with IQ_PERF_COUNTERS_EN, counters read 0.
